// File: rtl/dut_access_arbiter_if.sv
// dut_access_arbiter_if: request/response handshake between one requester and the arbiter
// Signals:
//   req_valid/req_ready  request handshake, req_ready is a same-cycle accept
//   req_write            1 = write, 0 = read
//   req_addr/req_wdata   address and write data of the request
//   rsp_valid            one-cycle response pulse
//   rsp_data/rsp_err     read data (0 for writes/errors), timeout flag
// Modports: master = requester side, slave = arbiter side.
interface dut_access_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 1
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dut_access_arbiter.sv
// dut_access_arbiter: round-robin sharing of the bit-memory write/read methods between requesters A and B
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   a, b                      requester handshakes (slave side of dut_access_arbiter_if)
//   write_address/data/en     write method to the memory, write_en only while write_rdy
//   write_rdy                 write method ready
//   read_address/en           read method to the memory, read_en only while read_rdy
//   read_data, read_rdy       read result (valid in the read_en cycle), read method ready
// One transaction in flight: IDLE accepts, ISSUE waits for rdy or times out,
// the response is a registered pulse to the granted requester only.
module dut_access_arbiter #(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                CLK,
    input  logic                RST,
    dut_access_arbiter_if.slave a,
    dut_access_arbiter_if.slave b,
    output logic [ADDR_W-1:0]   write_address,
    output logic [DATA_W-1:0]   write_data,
    output logic                write_en,
    input  logic                write_rdy,
    output logic [ADDR_W-1:0]   read_address,
    output logic                read_en,
    input  logic [DATA_W-1:0]   read_data,
    input  logic                read_rdy
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_n;
    logic              last_grant;
    logic              grant;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CW-1:0]     cnt;
    logic              sel_a, sel_b, accept, done, timeout;
    logic              rsp_a, rsp_b, rsp_err;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        state_n       = state;
        sel_a         = 1'b0;
        sel_b         = 1'b0;
        write_address = '0;
        write_data    = '0;
        write_en      = 1'b0;
        read_address  = '0;
        read_en       = 1'b0;
        timeout       = 1'b0;
        if (state == IDLE) begin
            // on a tie the requester that did not win last time goes first
            sel_a   = a.req_valid && (!b.req_valid || last_grant);
            sel_b   = b.req_valid && (!a.req_valid || !last_grant);
            state_n = (sel_a || sel_b) ? ISSUE : IDLE;
        end else begin
            if (lat_write) begin
                write_address = lat_addr;
                write_data    = lat_wdata;
                write_en      = write_rdy;
            end else begin
                read_address = lat_addr;
                read_en      = read_rdy;
            end
            // give up on the last allowed cycle only if the method is still not ready
            timeout = !(lat_write ? write_rdy : read_rdy) && (cnt == CNT_LAST);
            state_n = (write_en || read_en || timeout) ? IDLE : ISSUE;
        end
    end

    assign accept = sel_a || sel_b;
    assign done   = write_en || read_en || timeout;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            rsp_a      <= 1'b0;
            rsp_b      <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
        end else begin
            state    <= state_n;
            rsp_a    <= done && !grant;
            rsp_b    <= done && grant;
            rsp_err  <= timeout;
            rsp_data <= read_en ? read_data : '0;
            if (accept) begin
                grant      <= sel_b;
                last_grant <= sel_b;
                lat_write  <= sel_b ? b.req_write : a.req_write;
                lat_addr   <= sel_b ? b.req_addr  : a.req_addr;
                lat_wdata  <= sel_b ? b.req_wdata : a.req_wdata;
                cnt        <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign a.req_ready = sel_a;
    assign b.req_ready = sel_b;
    assign a.rsp_valid = rsp_a;
    assign b.rsp_valid = rsp_b;
    assign a.rsp_data  = rsp_a ? rsp_data : '0;
    assign b.rsp_data  = rsp_b ? rsp_data : '0;
    assign a.rsp_err   = rsp_a && rsp_err;
    assign b.rsp_err   = rsp_b && rsp_err;
endmodule

// File: tb/tb_dut_access_arbiter.sv
// tb_dut_access_arbiter: directed vector table plus multi-cycle sequences for dut_access_arbiter
module tb_dut_access_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] write_address, read_address;
    logic [0:0] write_data, read_data;
    logic       write_en, read_en, write_rdy, read_rdy;
    logic [0:0] mem [8];
    int         checks = 0;
    int         failures = 0;

    dut_access_arbiter_if #(.ADDR_W(3), .DATA_W(1)) a_if ();
    dut_access_arbiter_if #(.ADDR_W(3), .DATA_W(1)) b_if ();

    dut_access_arbiter #(.ADDR_W(3), .DATA_W(1), .TIMEOUT_CYC(16)) dut (
        .CLK(clk), .RST(rst), .a(a_if), .b(b_if),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write_en) mem[write_address] <= write_data;
    assign read_data = mem[read_address];

    typedef struct {
        logic       av, bv, wr;
        logic [2:0] addr;
        logic       wd;
        logic       g;
        logic       ed;
    } vec_t;
    vec_t v [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic bv, input logic wr, input logic [2:0] addr, input logic wd);
        a_if.req_valid = av; a_if.req_write = wr; a_if.req_addr = addr; a_if.req_wdata = wd;
        b_if.req_valid = bv; b_if.req_write = wr; b_if.req_addr = addr; b_if.req_wdata = wd;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_wen"}, int'(write_en), 0);
        chk({name, "_ren"}, int'(read_en), 0);
        chk({name, "_waddr"}, int'(write_address), 0);
        chk({name, "_raddr"}, int'(read_address), 0);
        chk({name, "_arsp"}, int'(a_if.rsp_valid), 0);
        chk({name, "_brsp"}, int'(b_if.rsp_valid), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        v[0] = '{1, 0, 1, 3'd5, 1, 0, 0};
        v[1] = '{1, 0, 0, 3'd5, 0, 0, 1};
        v[2] = '{0, 1, 1, 3'd2, 1, 1, 0};
        v[3] = '{1, 1, 0, 3'd2, 0, 0, 1};
        v[4] = '{1, 1, 1, 3'd7, 1, 1, 0};
        v[5] = '{0, 1, 0, 3'd7, 0, 1, 1};
        v[6] = '{1, 0, 0, 3'd3, 0, 0, 0};
        v[7] = '{1, 1, 0, 3'd7, 0, 1, 1};
        drive(0, 0, 0, 0, 0);
        write_rdy = 1'b0;
        read_rdy  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_ardy", int'(a_if.req_ready), 0);
        chk("reset_brdy", int'(b_if.req_ready), 0);

        for (int i = 0; i < 8; i++) begin
            tick();
            drive(v[i].av, v[i].bv, v[i].wr, v[i].addr, v[i].wd);
            write_rdy = 1'b1;
            read_rdy  = 1'b1;
            #1;
            chk($sformatf("v%0d_ardy", i), int'(a_if.req_ready), int'(!v[i].g));
            chk($sformatf("v%0d_brdy", i), int'(b_if.req_ready), int'(v[i].g));
            tick();
            drive(0, 0, 0, 0, 0);
            #1;
            chk($sformatf("v%0d_wen", i), int'(write_en), int'(v[i].wr));
            chk($sformatf("v%0d_ren", i), int'(read_en), int'(!v[i].wr));
            chk($sformatf("v%0d_addr", i), int'(v[i].wr ? write_address : read_address), int'(v[i].addr));
            if (v[i].wr) chk($sformatf("v%0d_wdata", i), int'(write_data), int'(v[i].wd));
            tick();
            chk($sformatf("v%0d_arsp", i), int'(a_if.rsp_valid), int'(!v[i].g));
            chk($sformatf("v%0d_brsp", i), int'(b_if.rsp_valid), int'(v[i].g));
            chk($sformatf("v%0d_data", i), int'(v[i].g ? b_if.rsp_data : a_if.rsp_data), int'(v[i].ed));
            chk($sformatf("v%0d_err", i), int'(a_if.rsp_err | b_if.rsp_err), 0);
        end

        // write stalled three cycles by write_rdy
        tick();
        drive(1, 0, 1, 3'd4, 1);
        write_rdy = 1'b0;
        #1;
        chk("stall_ardy", int'(a_if.req_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_wen", k), int'(write_en), 0);
            chk($sformatf("stall%0d_waddr", k), int'(write_address), 4);
            chk($sformatf("stall%0d_arsp", k), int'(a_if.rsp_valid), 0);
            tick();
        end
        write_rdy = 1'b1;
        #1;
        chk("stall_wen", int'(write_en), 1);
        tick();
        chk("stall_arsp", int'(a_if.rsp_valid), 1);
        chk("stall_err", int'(a_if.rsp_err), 0);

        // read timeout after 16 ISSUE cycles, then a normal read
        tick();
        drive(1, 0, 0, 3'd5, 0);
        read_rdy = 1'b0;
        #1;
        chk("to_ardy", int'(a_if.req_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("to%0d_ren", k), int'(read_en), 0);
            chk($sformatf("to%0d_arsp", k), int'(a_if.rsp_valid), 0);
            tick();
        end
        chk("to_arsp", int'(a_if.rsp_valid), 1);
        chk("to_err", int'(a_if.rsp_err), 1);
        chk("to_data", int'(a_if.rsp_data), 0);
        chk("to_brsp", int'(b_if.rsp_valid), 0);
        drive(1, 0, 0, 3'd5, 0);
        read_rdy = 1'b1;
        #1;
        chk("after_to_ardy", int'(a_if.req_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("after_to_ren", int'(read_en), 1);
        tick();
        chk("after_to_data", int'(a_if.rsp_data), 1);
        chk("after_to_err", int'(a_if.rsp_err), 0);

        // reset during ISSUE drops the transaction
        tick();
        drive(1, 0, 1, 3'd6, 1);
        write_rdy = 1'b0;
        #1;
        chk("rst_ardy", int'(a_if.req_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        chk("rst_issue_waddr", int'(write_address), 6);
        tick();
        rst = 1'b0;
        write_rdy = 1'b1;
        chk_quiet("rst_mid");
        tick();
        chk("rst_nopulse_a", int'(a_if.rsp_valid), 0);
        chk("rst_nopulse_b", int'(b_if.rsp_valid), 0);

        // both requesting continuously: A first after reset, then alternating
        a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_addr = 3'd1; a_if.req_wdata = 1'b1;
        b_if.req_valid = 1'b1; b_if.req_write = 1'b1; b_if.req_addr = 3'd0; b_if.req_wdata = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("rr%0d_both", c), int'(a_if.req_ready && b_if.req_ready), 0);
            if (a_if.req_ready || b_if.req_ready) begin
                chk($sformatf("rr_grant%0d", n), int'(b_if.req_ready), n % 2);
                n++;
            end
            tick();
        end
        chk("rr_count", n, 6);
        drive(0, 0, 0, 0, 0);
        chk("mem6_untouched", int'(mem[6]), 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
